// File: rtl/cp0_exception_if.sv
// cp0_exception_if
//   Bundles the memory-stage signals exchanged between the pipeline and the
//   CP0/exception unit. There is no valid/ready handshake: every input is
//   sampled on each rising clock edge, and every output is combinational from
//   the inputs and the current CP0 state in the same cycle.
//
//   master : pipeline side. It drives the exception flags, the PC, the MTC0
//            write and the MFC0 read address.
//   slave  : CP0 side. It drives the read data, the flush/redirect and the
//            register taps.
interface cp0_exception_if;
    logic [5:0]  int_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic        adel_if_i;
    logic        ri_i;
    logic        ov_i;
    logic        syscall_i;
    logic        break_i;
    logic        adel_i;
    logic        ades_i;
    logic        eret_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [4:0]  cp0_raddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] cp0_rdata_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    modport master (
        output int_i, pc_i, in_delayslot_i, bad_addr_i,
               adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
               cp0_we_i, cp0_waddr_i, cp0_raddr_i, cp0_wdata_i,
        input  cp0_rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
    );

    modport slave (
        input  int_i, pc_i, in_delayslot_i, bad_addr_i,
               adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
               cp0_we_i, cp0_waddr_i, cp0_raddr_i, cp0_wdata_i,
        output cp0_rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
    );
endinterface

// File: rtl/cp0_exception.sv
// cp0_exception
//   Coprocessor-0 register file (Status, Cause, EPC, BadVAddr, Count, Compare)
//   and the precise-exception unit for the memory stage of the 5-stage core.
//   It decides in the same cycle whether to flush IF..MEM and redirect fetch
//   either to EXC_VECTOR or to EPC (for ERET).
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - cp0_exception_if.slave. It carries the interrupts, the PC and
//            delay-slot flag, the faulting address, the exception flags, the
//            MTC0/MFC0 access, the flush/new_pc redirect and the
//            status/cause/epc taps.
//
//   Build option:
//     CP0_TIMER_EN - when defined, Count/Compare and the timer interrupt
//                    (folded into IP7) are implemented. When undefined,
//                    Count and Compare read as 0 and ignore writes.
module cp0_exception #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input logic            clk,
    input logic            rst,
    cp0_exception_if.slave bus
);

    // Status bits that software may change: IM[15:8], EXL, IE.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] badVAddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timerPending;

    logic        intPending;
    logic        excTaken;
    logic [4:0]  excCode;
    logic        badWe;
    logic [31:0] badVal;
    logic        eretTaken;
    logic        mtc0En;

    assign intPending = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

    // Fixed-priority exception select; the first match wins.
    always_comb begin
        excTaken = 1'b1;
        excCode  = 5'h00;
        badWe    = 1'b0;
        badVal   = 32'h0;
        if (intPending) begin
            excCode = 5'h00;
        end else if (bus.adel_if_i) begin
            excCode = 5'h04;
            badWe   = 1'b1;
            badVal  = bus.pc_i;
        end else if (bus.ri_i) begin
            excCode = 5'h0A;
        end else if (bus.ov_i) begin
            excCode = 5'h0C;
        end else if (bus.syscall_i) begin
            excCode = 5'h08;
        end else if (bus.break_i) begin
            excCode = 5'h09;
        end else if (bus.adel_i) begin
            excCode = 5'h04;
            badWe   = 1'b1;
            badVal  = bus.bad_addr_i;
        end else if (bus.ades_i) begin
            excCode = 5'h05;
            badWe   = 1'b1;
            badVal  = bus.bad_addr_i;
        end else begin
            excTaken = 1'b0;
        end
    end

    assign eretTaken = bus.eret_i & ~excTaken;
    // A redirect in this cycle discards the MTC0 of the same instruction.
    assign mtc0En    = bus.cp0_we_i & ~excTaken & ~eretTaken;

    assign bus.flush_o  = ~rst & (excTaken | eretTaken);
    assign bus.new_pc_o = excTaken ? EXC_VECTOR : epc;
    assign bus.status_o = status;
    assign bus.cause_o  = cause;
    assign bus.epc_o    = epc;

    always_comb begin
        bus.cp0_rdata_o = 32'h0;
        case (bus.cp0_raddr_i)
            5'd8:    bus.cp0_rdata_o = badVAddr;
            5'd9:    bus.cp0_rdata_o = count;
            5'd11:   bus.cp0_rdata_o = compare;
            5'd12:   bus.cp0_rdata_o = status;
            5'd13:   bus.cp0_rdata_o = cause;
            5'd14:   bus.cp0_rdata_o = epc;
            default: bus.cp0_rdata_o = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status   <= STATUS_RESET;
            cause    <= 32'h0;
            epc      <= 32'h0;
            badVAddr <= 32'h0;
        end else begin
            // The hardware interrupt lines (plus the timer on IP7) are re-sampled every cycle.
            cause[15:10] <= {bus.int_i[5] | timerPending, bus.int_i[4:0]};
            if (excTaken) begin
                // A nested exception (EXL already set) keeps the original EPC/BD.
                if (!status[1]) begin
                    epc       <= bus.in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
                    cause[31] <= bus.in_delayslot_i;
                end
                status[1]  <= 1'b1;
                cause[6:2] <= excCode;
                if (badWe) begin
                    badVAddr <= badVal;
                end
            end else if (eretTaken) begin
                status[1] <= 1'b0;
            end else if (mtc0En) begin
                case (bus.cp0_waddr_i)
                    5'd12:   status    <= (status & ~STATUS_WMASK) | (bus.cp0_wdata_i & STATUS_WMASK);
                    5'd13:   cause[9:8] <= bus.cp0_wdata_i[9:8];
                    5'd14:   epc       <= bus.cp0_wdata_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    // Count advances on every other edge; the toggle selects which edge.
    logic countToggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 32'h0;
            compare      <= 32'h0;
            timerPending <= 1'b0;
            countToggle  <= 1'b0;
        end else begin
            countToggle <= ~countToggle;
            if (mtc0En && bus.cp0_waddr_i == 5'd9) begin
                count <= bus.cp0_wdata_i;
            end else if (countToggle) begin
                count <= count + 32'd1;
            end
            // Writing Compare acknowledges the timer interrupt.
            if (mtc0En && bus.cp0_waddr_i == 5'd11) begin
                compare      <= bus.cp0_wdata_i;
                timerPending <= 1'b0;
            end else if (count == compare && compare != 32'h0) begin
                timerPending <= 1'b1;
            end
        end
    end
`else
    assign count        = 32'h0;
    assign compare      = 32'h0;
    assign timerPending = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_exception.sv
module tb_cp0_exception;

    localparam logic [31:0] EXC_VEC    = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exception_if bus();

    cp0_exception #(.EXC_VECTOR(EXC_VEC), .STATUS_RESET(STATUS_RST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] mStatus, mCause, mEpc, mBad, mCount, mCompare;
    logic        mTp;
    int          mEdge;   // edges since reset released; Count moves on odd ones

    function automatic void m_select(output logic taken, output logic [4:0] code,
                                     output logic badW, output logic [31:0] badV);
        logic       flags [8];
        logic [4:0] codes [8];
        flags[0] = mStatus[0] && !mStatus[1] && ((mCause[15:8] & mStatus[15:8]) != 8'h0);
        flags[1] = bus.adel_if_i; flags[2] = bus.ri_i;    flags[3] = bus.ov_i;
        flags[4] = bus.syscall_i; flags[5] = bus.break_i; flags[6] = bus.adel_i;
        flags[7] = bus.ades_i;
        codes[0] = 5'h00; codes[1] = 5'h04; codes[2] = 5'h0A; codes[3] = 5'h0C;
        codes[4] = 5'h08; codes[5] = 5'h09; codes[6] = 5'h04; codes[7] = 5'h05;
        taken = 1'b0; code = 5'h0; badW = 1'b0; badV = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (flags[i] && !taken) begin
                taken = 1'b1;
                code  = codes[i];
                if (i == 1) begin badW = 1'b1; badV = bus.pc_i; end
                if (i == 6 || i == 7) begin badW = 1'b1; badV = bus.bad_addr_i; end
            end
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return mBad;
            5'd9:  return mCount;
            5'd11: return mCompare;
            5'd12: return mStatus;
            5'd13: return mCause;
            5'd14: return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_edge();
        logic taken, badW, eret, wr;
        logic [4:0] code;
        logic [31:0] badV, nCount;
        logic nTp;
        if (rst) begin
            mStatus = STATUS_RST; mCause = 0; mEpc = 0; mBad = 0;
            mCount = 0; mCompare = 0; mTp = 0; mEdge = 0;
            return;
        end
        m_select(taken, code, badW, badV);
        eret = bus.eret_i && !taken;
        wr   = bus.cp0_we_i && !taken && !eret;
        nCount = mCount;
        nTp    = mTp;
`ifdef CP0_TIMER_EN
        if (wr && bus.cp0_waddr_i == 9) nCount = bus.cp0_wdata_i;
        else if (mEdge % 2 == 1) nCount = mCount + 1;
        if (wr && bus.cp0_waddr_i == 11) nTp = 1'b0;
        else if (mCount == mCompare && mCompare != 0) nTp = 1'b1;
        if (wr && bus.cp0_waddr_i == 11) mCompare = bus.cp0_wdata_i;
`endif
        mCause[15:10] = {bus.int_i[5] | mTp, bus.int_i[4:0]};
        if (taken) begin
            if (mStatus[1] == 1'b0) begin
                mEpc      = bus.in_delayslot_i ? bus.pc_i - 4 : bus.pc_i;
                mCause[31] = bus.in_delayslot_i;
            end
            mStatus[1]  = 1'b1;
            mCause[6:2] = code;
            if (badW) mBad = badV;
        end else if (eret) begin
            mStatus[1] = 1'b0;
        end else if (wr) begin
            if (bus.cp0_waddr_i == 12) begin
                mStatus[15:8] = bus.cp0_wdata_i[15:8];
                mStatus[1:0]  = bus.cp0_wdata_i[1:0];
            end
            if (bus.cp0_waddr_i == 13) mCause[9:8] = bus.cp0_wdata_i[9:8];
            if (bus.cp0_waddr_i == 14) mEpc = bus.cp0_wdata_i;
        end
        mCount = nCount;
        mTp    = nTp;
        mEdge++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.int_i = 6'h0; bus.pc_i = 32'h0; bus.in_delayslot_i = 1'b0; bus.bad_addr_i = 32'h0;
        bus.adel_if_i = 0; bus.ri_i = 0; bus.ov_i = 0; bus.syscall_i = 0; bus.break_i = 0;
        bus.adel_i = 0; bus.ades_i = 0; bus.eret_i = 0;
        bus.cp0_we_i = 0; bus.cp0_waddr_i = 5'd0; bus.cp0_raddr_i = 5'd0; bus.cp0_wdata_i = 32'h0;
    endtask

    // Advance one clock: model follows the same edge, outputs sampled 1 time unit after it.
    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = a; bus.cp0_wdata_i = d;
        tick();
        bus.cp0_we_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        bus.cp0_raddr_i = 5'd12; #1;
        checks++; if (bus.cp0_rdata_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h expected %h", bus.cp0_rdata_o, 32'h0040_0000); end
        bus.cp0_raddr_i = 5'd13; #1;
        checks++; if (bus.cp0_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_cause got %h expected 0", bus.cp0_rdata_o); end
        bus.cp0_raddr_i = 5'd14; #1;
        checks++; if (bus.cp0_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_epc got %h expected 0", bus.cp0_rdata_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b expected 0", bus.flush_o); end
    endtask

    task automatic test_syscall();
        bus.syscall_i = 1; bus.pc_i = 32'hBFC0_0100; bus.in_delayslot_i = 0; #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hBFC0_0380) begin errors++; $display("FAIL syscall_redirect got flush=%b pc=%h expected 1 bfc00380", bus.flush_o, bus.new_pc_o); end
        tick();
        clear_inputs(); #1;
        checks++; if (bus.epc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL syscall_epc got %h expected bfc00100", bus.epc_o); end
        checks++; if (bus.cause_o[6:2] !== 5'h08 || bus.status_o[1] !== 1'b1) begin errors++; $display("FAIL syscall_code_exl got code=%h exl=%b expected 08 1", bus.cause_o[6:2], bus.status_o[1]); end
        bus.eret_i = 1; #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL syscall_eret got flush=%b pc=%h expected 1 bfc00100", bus.flush_o, bus.new_pc_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_ades_eret();
        bus.ades_i = 1; bus.in_delayslot_i = 1; bus.pc_i = 32'h8000_0010; bus.bad_addr_i = 32'h8000_1003;
        tick();
        clear_inputs(); bus.cp0_raddr_i = 5'd8; #1;
        checks++; if (bus.epc_o !== 32'h8000_000C || bus.cause_o[31] !== 1'b1) begin errors++; $display("FAIL ades_epc_bd got epc=%h bd=%b expected 8000000c 1", bus.epc_o, bus.cause_o[31]); end
        checks++; if (bus.cp0_rdata_o !== 32'h8000_1003) begin errors++; $display("FAIL ades_badvaddr got %h expected 80001003", bus.cp0_rdata_o); end
        checks++; if (bus.cause_o[6:2] !== 5'h05) begin errors++; $display("FAIL ades_code got %h expected 05", bus.cause_o[6:2]); end
        bus.eret_i = 1; #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h8000_000C) begin errors++; $display("FAIL ades_eret got flush=%b pc=%h expected 1 8000000c", bus.flush_o, bus.new_pc_o); end
        tick();
        clear_inputs(); #1;
        checks++; if (bus.status_o[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got %b expected 0", bus.status_o[1]); end
    endtask

    // Second exception while EXL=1 must keep EPC from the first one.
    task automatic test_back_to_back();
        bus.syscall_i = 1; bus.pc_i = 32'h8000_0100;
        tick();
        clear_inputs(); bus.break_i = 1; bus.pc_i = 32'h8000_0104; #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== EXC_VEC) begin errors++; $display("FAIL b2b_redirect got flush=%b pc=%h expected 1 %h", bus.flush_o, bus.new_pc_o, EXC_VEC); end
        tick();
        clear_inputs(); #1;
        checks++; if (bus.epc_o !== 32'h8000_0100 || bus.cause_o[6:2] !== 5'h09) begin errors++; $display("FAIL b2b_epc_code got epc=%h code=%h expected 80000100 09", bus.epc_o, bus.cause_o[6:2]); end
        bus.eret_i = 1; bus.ri_i = 1; #1;
        checks++; if (bus.new_pc_o !== EXC_VEC) begin errors++; $display("FAIL exc_over_eret got %h expected %h", bus.new_pc_o, EXC_VEC); end
        tick();
        clear_inputs(); bus.eret_i = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        bus.int_i = 6'h01; bus.pc_i = 32'h8000_0200; #1;
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL int_before_sample got %b expected 0", bus.flush_o); end
        tick(); #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== EXC_VEC) begin errors++; $display("FAIL int_taken got flush=%b pc=%h expected 1 %h", bus.flush_o, bus.new_pc_o, EXC_VEC); end
        tick(); #1;
        checks++; if (bus.cause_o[6:2] !== 5'h00 || bus.status_o[1] !== 1'b1 || bus.epc_o !== 32'h8000_0200) begin errors++; $display("FAIL int_code got code=%h exl=%b epc=%h expected 00 1 80000200", bus.cause_o[6:2], bus.status_o[1], bus.epc_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL int_masked_exl got %b expected 0", bus.flush_o); end
        bus.int_i = 6'h00; bus.eret_i = 1;
        tick();
        clear_inputs();
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_mtc0_suppress();
        bus.ri_i = 1; bus.pc_i = 32'h8000_0400;
        bus.cp0_we_i = 1; bus.cp0_waddr_i = 5'd14; bus.cp0_wdata_i = 32'hDEAD_BEEF;
        tick();
        clear_inputs(); #1;
        checks++; if (bus.epc_o !== 32'h8000_0400 || bus.cause_o[6:2] !== 5'h0A) begin errors++; $display("FAIL mtc0_suppress got epc=%h code=%h expected 80000400 0a", bus.epc_o, bus.cause_o[6:2]); end
        bus.eret_i = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_EN
        int n;
        mtc0(5'd11, 32'd6);
        mtc0(5'd9, 32'd0);
        n = 0;
        while (bus.cause_o[15] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n < 12 || n > 15) begin errors++; $display("FAIL timer_ip7 cycles got %0d expected 12..15", n); end
        mtc0(5'd11, 32'd0);
        tick();
        checks++; if (bus.cause_o[15] !== 1'b0) begin errors++; $display("FAIL timer_clear got %b expected 0", bus.cause_o[15]); end
`else
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 20; i++) tick();
        bus.cp0_raddr_i = 5'd9; #1;
        checks++; if (bus.cp0_rdata_o !== 32'h0) begin errors++; $display("FAIL notimer_count got %h expected 0", bus.cp0_rdata_o); end
        bus.cp0_raddr_i = 5'd11; #1;
        checks++; if (bus.cp0_rdata_o !== 32'h0 || bus.cause_o[15] !== 1'b0) begin errors++; $display("FAIL notimer_compare got %h ip7=%b expected 0 0", bus.cp0_rdata_o, bus.cause_o[15]); end
`endif
    endtask

    task automatic test_random();
        logic taken, badW, eFlush;
        logic [4:0] code;
        logic [31:0] badV, ePc;
        int roll;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) bus.int_i = 6'($urandom);
            bus.pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.in_delayslot_i = $urandom_range(0, 1);
            bus.bad_addr_i = $urandom;
            bus.adel_if_i = ($urandom_range(0, 24) == 0);
            bus.ri_i      = ($urandom_range(0, 24) == 0);
            bus.ov_i      = ($urandom_range(0, 24) == 0);
            bus.syscall_i = ($urandom_range(0, 24) == 0);
            bus.break_i   = ($urandom_range(0, 24) == 0);
            bus.adel_i    = ($urandom_range(0, 24) == 0);
            bus.ades_i    = ($urandom_range(0, 24) == 0);
            bus.eret_i    = ($urandom_range(0, 9) == 0);
            bus.cp0_we_i  = ($urandom_range(0, 2) == 0);
            roll = $urandom_range(0, 7);
            case (roll)
                0: bus.cp0_waddr_i = 5'd8;
                1: bus.cp0_waddr_i = 5'd9;
                2: bus.cp0_waddr_i = 5'd11;
                3: bus.cp0_waddr_i = 5'd12;
                4: bus.cp0_waddr_i = 5'd13;
                5: bus.cp0_waddr_i = 5'd14;
                default: bus.cp0_waddr_i = 5'($urandom);
            endcase
            bus.cp0_wdata_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            bus.cp0_raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(8 + $urandom_range(0, 6));
            #1;
            m_select(taken, code, badW, badV);
            eFlush = !rst && (taken || bus.eret_i);
            ePc    = taken ? EXC_VEC : mEpc;
            checks++; if (bus.flush_o !== eFlush) begin errors++; $display("FAIL rand_flush cyc %0d got %b expected %b", cyc, bus.flush_o, eFlush); end
            if (eFlush) begin
                checks++; if (bus.new_pc_o !== ePc) begin errors++; $display("FAIL rand_new_pc cyc %0d got %h expected %h", cyc, bus.new_pc_o, ePc); end
            end
            checks++; if (bus.cp0_rdata_o !== m_read(bus.cp0_raddr_i)) begin errors++; $display("FAIL rand_rdata cyc %0d addr %0d got %h expected %h", cyc, bus.cp0_raddr_i, bus.cp0_rdata_o, m_read(bus.cp0_raddr_i)); end
            checks++; if (bus.status_o !== mStatus || bus.cause_o !== mCause || bus.epc_o !== mEpc) begin errors++; $display("FAIL rand_regs cyc %0d got %h %h %h expected %h %h %h", cyc, bus.status_o, bus.cause_o, bus.epc_o, mStatus, mCause, mEpc); end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.syscall_i = 1; bus.pc_i = 32'h8000_0800; bus.cp0_we_i = 1; bus.cp0_waddr_i = 5'd14; bus.cp0_wdata_i = 32'h1234_5678;
        rst = 1'b1; #1;
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_mid_flush got %b expected 0", bus.flush_o); end
        tick();
        rst = 1'b0; clear_inputs(); #1;
        checks++; if (bus.status_o !== STATUS_RST || bus.epc_o !== 32'h0 || bus.cause_o !== 32'h0) begin errors++; $display("FAIL reset_mid_regs got %h %h %h expected %h 0 0", bus.status_o, bus.epc_o, bus.cause_o, STATUS_RST); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_syscall();
        test_ades_eret();
        test_back_to_back();
        test_interrupt();
        test_mtc0_suppress();
        test_timer();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
